debounce_multi: RTL

Multi-channel debouncer for push buttons and switches, generalising the single-button debouncer.
- Each channel has a synchroniser and a saturating integrating counter.
- Two thresholds give hysteresis between press and release decisions.
- Each channel produces a debounced level, one-cycle press/release pulses and a long-press pulse.
- The block sits between board pins and the transmit trigger or other user-command logic.

---
 rtl/debounce_pkg.sv | 28 ++
 rtl/debounce_channel.sv | 103 ++++++++++
 rtl/debounce_multi.sv | 76 +++++++
 3 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pkg
//  Description : Shared defaults and width helpers for the multi-channel
//                button debouncer.
//  Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    localparam int c_def_channels    = 4;
    localparam int c_def_sync_stages = 2;
    localparam int c_def_cnt_w       = 21;
    localparam int c_def_th_on       = 1000000;
    localparam int c_def_th_off      = 500000;
    localparam int c_def_hold_cycles = 50000000;

    // Saturation value of an integrating counter of the given width.
    function automatic longint unsigned cnt_max(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

    // Bits needed to hold the values 0..hold inclusive.
    function automatic int hold_width(input longint hold);
        return (hold < 1) ? 1 : $clog2(hold + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : One debounce channel: synchroniser, saturating integrator,
//                hysteresis level, edge pulses and long-press detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = c_def_sync_stages,
    parameter int CNT_W       = c_def_cnt_w,
    parameter int TH_ON       = c_def_th_on,
    parameter int TH_OFF      = c_def_th_off,
    parameter int HOLD_CYCLES = c_def_hold_cycles
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_press
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] c_th_on   = CNT_W'(TH_ON);
    localparam logic [CNT_W-1:0] c_th_off  = CNT_W'(TH_OFF);
    localparam int               c_hold_w  = hold_width(HOLD_CYCLES);
    localparam logic [c_hold_w-1:0] c_hold_max  = c_hold_w'(HOLD_CYCLES);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic [c_hold_w-1:0]    r_hold;
    logic                   r_long;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn};
        end
    end

    // Integrator saturates at both ends so a long press never wraps to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_s && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (!w_s && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Decisions use the pre-update count; the gap between thresholds holds level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (!r_level && (r_cnt > c_th_on)) begin
                r_level <= 1'b1;
                r_rise  <= 1'b1;
            end else if (r_level && (r_cnt < c_th_off)) begin
                r_level <= 1'b0;
                r_fall  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (!r_level) begin
                r_hold <= '0;
            end else if (r_hold != c_hold_max) begin
                r_hold <= r_hold + 1'b1;
                r_long <= (r_hold == c_hold_last);
            end
        end
    end

    assign level      = r_level;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign long_press = r_long;

endmodule
`default_nettype wire

// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_multi
//  Description : Array of independent debounce channels plus a registered
//                "any button down" flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int CHANNELS    = c_def_channels,
    parameter int SYNC_STAGES = c_def_sync_stages,
    parameter int CNT_W       = c_def_cnt_w,
    parameter int TH_ON       = c_def_th_on,
    parameter int TH_OFF      = c_def_th_off,
    parameter int HOLD_CYCLES = c_def_hold_cycles
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] long_press,
    output logic                any_level
);

    if (CHANNELS < 1) begin : g_chk_channels
        $fatal(1, "debounce_multi: CHANNELS must be >= 1");
    end
    if (TH_OFF >= TH_ON) begin : g_chk_th_order
        $fatal(1, "debounce_multi: TH_OFF must be below TH_ON");
    end
    if ((64'(TH_ON) + 64'd1) > cnt_max(CNT_W)) begin : g_chk_th_range
        $fatal(1, "debounce_multi: TH_ON must not exceed CNT_MAX-1");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $fatal(1, "debounce_multi: SYNC_STAGES must be >= 2");
    end
    if (HOLD_CYCLES < 1) begin : g_chk_hold
        $fatal(1, "debounce_multi: HOLD_CYCLES must be >= 1");
    end

    logic r_any_level;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .TH_ON       (TH_ON),
            .TH_OFF      (TH_OFF),
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_channel (
            .clk        (clk),
            .rst        (rst),
            .btn        (btn[i]),
            .level      (level[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .long_press (long_press[i])
        );
    end

    // Built from the registered levels, so it trails them by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_any_level <= 1'b0;
        end else begin
            r_any_level <= |level;
        end
    end

    assign any_level = r_any_level;

endmodule
`default_nettype wire
